pc_unit: RTL and testbench

- Parametrised program-counter unit for the in-order RV32 core's IF stage. Successor to the fixed 32-bit PC register.
- Adds the following over its predecessor:
  - a fetch request/grant handshake;
  - a pipeline stall input;
  - redirect buffering while stalled;
  - a trap vector path;
  - a HALT state machine.
- Drives the instruction-memory word address and exposes the full PC to ID/EX.

---
 rtl/pc_pkg.sv | 7 +
 rtl/pc_redirect_buf.sv | 39 +++
 rtl/pc_unit.sv | 69 ++++++
 tb/tb_pc_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the IF-stage program-counter unit.
package pc_pkg;
  localparam int ADDR_W = 32;
  localparam int INSN_BYTES = 4;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic {PC_RUN, PC_HALTED} pc_state_e;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: buffers a redirect taken during a stall and selects the redirect to apply.
// With PC_MISALIGN_TRAP_EN a misaligned target is flagged instead of being masked.
module pc_redirect_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            trap_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] target_i,
  output logic            pending_o,
  output logic            apply_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] target_o
);
  logic            pend_q, pend_d;
  logic [XLEN-1:0] tgt_q, tgt_d, raw;
  assign apply_o   = ~trap_i & ~stall_i & (valid_i | pend_q);
  assign raw       = valid_i ? target_i : tgt_q;
  assign pend_d    = ~trap_i & stall_i & (valid_i | pend_q);
  assign tgt_d     = (~trap_i & stall_i & valid_i) ? target_i : tgt_q;
  assign pending_o = pend_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign target_o   = raw;
  assign misalign_o = apply_o & (|raw[1:0]);
`else
  assign target_o   = raw & ~XLEN'(2'b11);
  assign misalign_o = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage PC with fetch handshake, stall, buffered redirects, trap vector and HALT FSM.
// Optional misaligned-redirect trap enabled by PC_MISALIGN_TRAP_EN.
module pc_unit #(
  parameter int              XLEN     = 32,
  parameter int              IMEM_AW  = 14,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] HALT_PC  = 32'd800,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  input  logic               trap_valid,
  output logic               if_req,
  input  logic               if_gnt,
  output logic [IMEM_AW-1:0] if_addr,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  output logic               redirect_pending,
  output logic               halted,
  output logic               misalign_err
);
  import pc_pkg::*;
  localparam logic [0:0] ST_RUN    = 1'(PC_RUN);
  localparam logic [0:0] ST_HALTED = 1'(PC_HALTED);
  logic [XLEN-1:0] pc_q, pc_d, rd_target;
  logic [0:0]      state_q, state_d;
  logic            live_q, mis_q, rd_apply, rd_mis, step, at_halt;
  pc_redirect_buf #(.XLEN(XLEN)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .trap_i     (trap_valid),
    .valid_i    (redirect_valid),
    .target_i   (redirect_target),
    .pending_o  (redirect_pending),
    .apply_o    (rd_apply),
    .misalign_o (rd_mis),
    .target_o   (rd_target)
  );
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + XLEN'(INSN_BYTES);
  assign if_addr  = pc_q[IMEM_AW+1:2];
  // live_q keeps if_req low for the first cycle after reset release
  assign if_req       = live_q & (state_q == ST_RUN);
  assign halted       = state_q == ST_HALTED;
  assign misalign_err = mis_q;
  assign step    = if_req & ~stall & if_gnt;
  assign at_halt = pc_q == HALT_PC;
  assign pc_d    = trap_valid ? TRAP_VEC :
                   rd_apply   ? (rd_mis ? TRAP_VEC : rd_target) :
                   (step & ~at_halt) ? pc_plus4 : pc_q;
  assign state_d = (trap_valid | rd_apply) ? ST_RUN :
                   (step & at_halt) ? ST_HALTED : state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      live_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      live_q  <= 1'b1;
      mis_q   <= rd_mis;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard-driven self-checking bench for pc_unit.
module tb_pc_unit;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic        clk = 0, rst = 0, stall = 0, redirect_valid = 0, trap_valid = 0, if_gnt = 0;
  logic [31:0] redirect_target = 0;
  logic        if_req, redirect_pending, halted, misalign_err;
  logic [13:0] if_addr;
  logic [31:0] pc, pc_plus4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [13:0] addr;
    logic        req, pend, hlt, mis;
  } obs_t;
  typedef struct {
    logic        s, rv, tv;
    logic [31:0] t, epc;
    logic        ereq, epend, ehlt, emis;
  } step_t;
  obs_t sb[$];
  obs_t e, o;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap_valid(trap_valid), .if_req(if_req),
    .if_gnt(if_gnt), .if_addr(if_addr), .pc(pc), .pc_plus4(pc_plus4),
    .redirect_pending(redirect_pending), .halted(halted), .misalign_err(misalign_err)
  );
  function automatic obs_t mk(input logic [31:0] p, input logic r, input logic pd, input logic h, input logic m);
    logic [31:0] q;
    q = p + 32'd4;
    return '{pc: p, p4: q, addr: p[15:2], req: r, pend: pd, hlt: h, mis: m};
  endfunction
  function automatic obs_t sample();
    return '{pc: pc, p4: pc_plus4, addr: if_addr, req: if_req, pend: redirect_pending, hlt: halted, mis: misalign_err};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic rv, input logic tv, input logic g, input logic [31:0] t);
    stall = s; redirect_valid = rv; trap_valid = tv; if_gnt = g; redirect_target = t;
  endtask
  task automatic test_reset();
    #1 rst = 1;
    #2;
    e = mk(32'h0, 0, 0, 0, 0); o = sample(); checks++;
    if (o !== e) $display("FAIL reset_state got=%h want=%h", o, e); else passes++;
    #9 rst = 0;
    #1;
    o = sample(); checks++;
    if (o !== e) $display("FAIL reset_release_req got=%h want=%h", o, e); else passes++;
    drive(0, 0, 0, 1, 0);
    sb.push_back(mk(32'h0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) $display("FAIL first_edge got=%h want=%h", o, e); else passes++;
  endtask
  task automatic test_sequential();
    for (int i = 1; i <= 2; i++) begin
      drive(0, 0, 0, 1, 0);
      sb.push_back(mk(32'(4 * i), 1, 0, 0, 0));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL seq_step%0d got=%h want=%h", i, o, e); else passes++;
    end
  endtask
  task automatic test_no_grant();
    logic [2:0]  g = 3'b100;
    logic [31:0] ep[3] = '{32'd8, 32'd8, 32'd12};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, g[i], 0);
      sb.push_back(mk(ep[i], 1, 0, 0, 0));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL no_grant%0d got=%h want=%h", i, o, e); else passes++;
    end
  endtask
  task automatic test_stall_redirect();
    step_t st[9] = '{
      '{1, 1, 0, 32'h40, 32'd12, 1, 1, 0, 0},
      '{1, 1, 0, 32'h40, 32'd12, 1, 1, 0, 0},
      '{1, 1, 0, 32'h40, 32'd12, 1, 1, 0, 0},
      '{0, 0, 0, 32'h0,  32'h40, 1, 0, 0, 0},
      '{1, 1, 0, 32'h20, 32'h40, 1, 1, 0, 0},
      '{1, 1, 0, 32'h60, 32'h40, 1, 1, 0, 0},
      '{0, 0, 0, 32'h0,  32'h60, 1, 0, 0, 0},
      '{1, 1, 0, 32'h20, 32'h60, 1, 1, 0, 0},
      '{0, 1, 0, 32'h30, 32'h30, 1, 0, 0, 0}
    };
    for (int i = 0; i < 9; i++) begin
      drive(st[i].s, st[i].rv, st[i].tv, 1, st[i].t);
      sb.push_back(mk(st[i].epc, st[i].ereq, st[i].epend, st[i].ehlt, st[i].emis));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL stall_redirect%0d got=%h want=%h", i, o, e); else passes++;
    end
  endtask
  task automatic test_trap_halt();
    step_t st[19];
    drive(1, 1, 1, 1, 32'h80);
    sb.push_back(mk(32'h100, 1, 0, 0, 0));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) $display("FAIL trap_vs_redirect got=%h want=%h", o, e); else passes++;
    for (int i = 1; i <= 136; i++) begin
      drive(0, 0, 0, 1, 0);
      sb.push_back(mk(32'h100 + 32'(4 * i), 1, 0, 0, 0));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL run_to_halt%0d got=%h want=%h", i, o, e); else passes++;
    end
    for (int i = 0; i < 11; i++) st[i] = '{0, 0, 0, 32'h0, 32'd800, 0, 0, 1, 0};
    st[11] = '{1, 1, 0, 32'h20,        32'd800,       0, 1, 1, 0};
    st[12] = '{0, 0, 0, 32'h0,         32'h20,        1, 0, 0, 0};
    st[13] = '{0, 1, 0, 32'd800,       32'd800,       1, 0, 0, 0};
    st[14] = '{0, 0, 0, 32'h0,         32'd800,       0, 0, 1, 0};
    st[15] = '{0, 1, 0, 32'h10,        32'h10,        1, 0, 0, 0};
    st[16] = '{0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0};
    st[17] = '{0, 0, 0, 32'h0,         32'h0,         1, 0, 0, 0};
    st[18] = '{0, 0, 1, 32'h0,         32'h100,       1, 0, 0, 0};
    for (int i = 0; i < 19; i++) begin
      drive(st[i].s, st[i].rv, st[i].tv, 1, st[i].t);
      sb.push_back(mk(st[i].epc, st[i].ereq, st[i].epend, st[i].ehlt, st[i].emis));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL halt_seq%0d got=%h want=%h", i, o, e); else passes++;
    end
  endtask
  task automatic test_misalign();
    logic [31:0] p1 = MIS ? 32'h100 : 32'h40;
    logic [31:0] p2 = MIS ? 32'h100 : 32'h44;
    step_t st[6] = '{
      '{0, 1, 0, 32'h42, p1,      1, 0, 0, MIS},
      '{0, 0, 0, 32'h0,  p1,      1, 0, 0, 0},
      '{1, 1, 0, 32'h46, p1,      1, 1, 0, 0},
      '{0, 0, 0, 32'h0,  p2,      1, 0, 0, MIS},
      '{0, 0, 0, 32'h0,  p2,      1, 0, 0, 0},
      '{0, 1, 1, 32'h42, 32'h100, 1, 0, 0, 0}
    };
    for (int i = 0; i < 6; i++) begin
      drive(st[i].s, st[i].rv, st[i].tv, 0, st[i].t);
      sb.push_back(mk(st[i].epc, st[i].ereq, st[i].epend, st[i].ehlt, st[i].emis));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL misalign%0d got=%h want=%h", i, o, e); else passes++;
    end
  endtask
  task automatic test_async_reset();
    drive(1, 1, 0, 1, 32'h40);
    sb.push_back(mk(32'h100, 1, 1, 0, 0));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) $display("FAIL pend_before_rst got=%h want=%h", o, e); else passes++;
    #2 rst = 1;
    #1;
    e = mk(32'h0, 0, 0, 0, 0); o = sample(); checks++;
    if (o !== e) $display("FAIL async_rst got=%h want=%h", o, e); else passes++;
    drive(0, 0, 0, 1, 0);
    #2 rst = 0;
    sb.push_back(mk(32'h0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) $display("FAIL post_rst_edge got=%h want=%h", o, e); else passes++;
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_no_grant();
    test_stall_redirect();
    test_trap_halt();
    test_misalign();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
